// File: rtl/spi_egress_arbiter.sv
// Round-robin merge of NUM_SRC byte streams into one SPI egress stream, MTU-limited bursts.
// Define SPI_EGRESS_ARB_HEADER_EN to prefix each burst with a {HDR_TAG,2'b00,grant} header byte.
module spi_egress_arbiter #(
    parameter int         NUM_SRC   = 4,
    parameter int         MTU       = 16,
    parameter logic [3:0] HDR_TAG   = 4'hA,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC*8-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    input  logic [NUM_SRC-1:0]   s_axis_tlast,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [7:0]           m_axis_tuser,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_SRC - 1);
    localparam logic [7:0] LAST_CNT = 8'(MTU - 1);

    state_t     state_q;
    logic [1:0] grant_q;
    logic [1:0] last_q;
    logic [7:0] cnt_q;

    // Sources padded to four lanes so a 2-bit grant indexes every build.
    logic [31:0] data4;
    logic [3:0]  vld4;
    logic [3:0]  lst4;
    logic [3:0]  rdy4;

    assign data4 = 32'(s_axis_tdata);
    assign vld4  = 4'(s_axis_tvalid);
    assign lst4  = 4'(s_axis_tlast);

    assign s_axis_tready = rdy4[NUM_SRC-1:0];
    assign m_axis_tuser  = IDLE_BYTE;
    assign grant_id      = grant_q;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        win   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
            if (!found && vld4[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        rdy4          = '0;
        busy          = 1'b0;
        if (!rst) begin
            busy = (state_q != IDLE);
            unique case (state_q)
                HEADER: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = {HDR_TAG, 2'b00, grant_q};
                end
                DATA: begin
                    m_axis_tvalid = vld4[grant_q];
                    m_axis_tdata  = data4[{grant_q, 3'b000} +: 8];
                    m_axis_tlast  = lst4[grant_q] || (cnt_q == LAST_CNT);
                    rdy4[grant_q] = m_axis_tready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_IDX;
            grant_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_q <= win;
                        cnt_q   <= '0;
`ifdef SPI_EGRESS_ARB_HEADER_EN
                        state_q <= HEADER;
`else
                        state_q <= DATA;
`endif
                    end
                end
                HEADER: begin
                    if (m_axis_tready) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end
                end
                DATA: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (m_axis_tlast) begin
                            state_q <= IDLE;
                            last_q  <= grant_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
